// File: rtl/pulse_cond_pkg.sv
// Shared definitions for the pulse conditioner: edge-select encodings,
// default parameter values and a small elaboration helper.
package pulse_cond_pkg;

    typedef enum logic [1:0] {
        MODE_OFF  = 2'b00,
        MODE_RISE = 2'b01,
        MODE_FALL = 2'b10,
        MODE_BOTH = 2'b11
    } mode_e;

    localparam int MODE_RISE_BIT = 0;
    localparam int MODE_FALL_BIT = 1;

    localparam int DEF_N           = 4;
    localparam int DEF_DB_CYCLES   = 500000;
    localparam int DEF_HOLD_CYCLES = 25000000;
    localparam int DEF_REP_CYCLES  = 5000000;

    function automatic int max_int(input int a, input int b);
        if (a > b) begin
            return a;
        end else begin
            return b;
        end
    endfunction

endpackage

// File: rtl/pulse_cond_chan.sv
// One channel of the pulse conditioner: synchroniser, debounce, edge pulse
// generation and auto-repeat for a single button input.
module pulse_chan
    import pulse_cond_pkg::*;
#(
    parameter int DB_CYCLES   = DEF_DB_CYCLES,
    parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
    parameter int REP_CYCLES  = DEF_REP_CYCLES
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       x,
    input  logic [1:0] mode,
    input  logic       rep_en,
    output logic       z,
    output logic       level
);

    localparam int DBW = $clog2(DB_CYCLES) + 1;
    localparam int RPW = $clog2(max_int(HOLD_CYCLES, REP_CYCLES)) + 1;
    localparam logic [DBW-1:0] DB_LAST   = DBW'(DB_CYCLES - 1);
    localparam logic [RPW-1:0] HOLD_LAST = RPW'(HOLD_CYCLES - 1);
    localparam logic [RPW-1:0] REP_LAST  = RPW'(REP_CYCLES - 1);

    logic           sync1_q, sync2_q;
    logic [DBW-1:0] db_cnt_q, db_cnt_d;
    logic           level_q, level_d;
    logic           z_q, z_d;
    logic           rep_run_q, rep_run_d;
    logic           rep_first_q, rep_first_d;
    logic [RPW-1:0] rep_cnt_q, rep_cnt_d;
    logic [RPW-1:0] rep_last_s;
    logic           toggle_s, rise_s, fall_s, rep_ok_s, rep_fire_s;

    assign rise_s     = toggle_s & ~level_q;
    assign fall_s     = toggle_s & level_q;
    assign rep_ok_s   = rep_en & mode[MODE_RISE_BIT];
    // The first repeat waits the long hold time, later ones the short period.
    assign rep_last_s = rep_first_q ? HOLD_LAST : REP_LAST;

    // Debounce: count consecutive disagreeing edges, toggle level after DB_CYCLES.
    always_comb begin
        db_cnt_d = db_cnt_q;
        level_d  = level_q;
        toggle_s = 1'b0;
        if (sync2_q == level_q) begin
            db_cnt_d = {DBW{1'b0}};
        end else if (db_cnt_q == DB_LAST) begin
            db_cnt_d = {DBW{1'b0}};
            level_d  = ~level_q;
            toggle_s = 1'b1;
        end else begin
            db_cnt_d = db_cnt_q + DBW'(1);
        end
    end

    // Auto-repeat timer: armed by a rise pulse, cancelled by fall or loss of enable.
    always_comb begin
        rep_run_d   = rep_run_q;
        rep_first_d = rep_first_q;
        rep_cnt_d   = rep_cnt_q;
        rep_fire_s  = 1'b0;
        if (!rep_ok_s || fall_s || (!level_q && !rise_s)) begin
            rep_run_d   = 1'b0;
            rep_first_d = 1'b0;
            rep_cnt_d   = {RPW{1'b0}};
        end else if (rise_s) begin
            rep_run_d   = 1'b1;
            rep_first_d = 1'b1;
            rep_cnt_d   = {RPW{1'b0}};
        end else if (rep_run_q) begin
            if (rep_cnt_q == rep_last_s) begin
                rep_fire_s  = 1'b1;
                rep_first_d = 1'b0;
                rep_cnt_d   = {RPW{1'b0}};
            end else begin
                rep_cnt_d = rep_cnt_q + RPW'(1);
            end
        end else begin
            rep_cnt_d = rep_cnt_q;
        end
    end

    // Output pulse: OR of the selected edge events and the repeat tick.
    always_comb begin
        z_d = (rise_s & mode[MODE_RISE_BIT]) | (fall_s & mode[MODE_FALL_BIT]) | rep_fire_s;
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            db_cnt_q    <= {DBW{1'b0}};
            level_q     <= 1'b0;
            z_q         <= 1'b0;
            rep_run_q   <= 1'b0;
            rep_first_q <= 1'b0;
            rep_cnt_q   <= {RPW{1'b0}};
        end else begin
            sync1_q     <= x;
            sync2_q     <= sync1_q;
            db_cnt_q    <= db_cnt_d;
            level_q     <= level_d;
            z_q         <= z_d;
            rep_run_q   <= rep_run_d;
            rep_first_q <= rep_first_d;
            rep_cnt_q   <= rep_cnt_d;
        end
    end

    assign z     = z_q;
    assign level = level_q;

endmodule

// File: rtl/pulse_cond.sv
// Multi-channel button conditioner: N independent debounce/edge/auto-repeat
// channels sharing one clock and one edge-select mode.
module pulse_cond
    import pulse_cond_pkg::*;
#(
    parameter int N           = DEF_N,
    parameter int DB_CYCLES   = DEF_DB_CYCLES,
    parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
    parameter int REP_CYCLES  = DEF_REP_CYCLES
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] x,
    input  logic [1:0]   mode,
    input  logic [N-1:0] rep_en,
    output logic [N-1:0] z,
    output logic [N-1:0] level
);

    for (genvar i = 0; i < N; i++) begin : g_chan
        pulse_chan #(
            .DB_CYCLES  (DB_CYCLES),
            .HOLD_CYCLES(HOLD_CYCLES),
            .REP_CYCLES (REP_CYCLES)
        ) u_chan (
            .clk   (clk),
            .rst_n (rst_n),
            .x     (x[i]),
            .mode  (mode),
            .rep_en(rep_en[i]),
            .z     (z[i]),
            .level (level[i])
        );
    end

endmodule

// File: tb/tb_pulse_cond.sv
// Bench for pulse_cond (N=2, DB=4, HOLD=8, REP=3): window-based reference
// model checked every cycle, plus directed scenarios with literal pulse times.
module tb_pulse_cond;
    import pulse_cond_pkg::*;

    localparam int D    = 4;
    localparam int H    = 8;
    localparam int R    = 3;
    localparam int MAXC = 2048;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] x;
    logic [1:0] mode;
    logic [1:0] rep_en;
    logic [1:0] z;
    logic [1:0] level;

    int n_chk  = 0;
    int n_fail = 0;
    int pz0[$];
    int pz1[$];

    pulse_cond #(.N(2), .DB_CYCLES(D), .HOLD_CYCLES(H), .REP_CYCLES(R)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .x     (x),
        .mode  (mode),
        .rep_en(rep_en),
        .z     (z),
        .level (level)
    );

    always #5 clk = ~clk;

    // Reference model: k counts non-reset edges; xh[ch][j] is x sampled at edge j.
    int         k = 2;
    bit         xh [2][MAXC];
    bit         m_lvl [2]    = '{1'b0, 1'b0};
    int         last_tog [2] = '{2, 2};
    int         rise_at [2]  = '{-1, -1};
    logic [1:0] exp_z   = 2'b00;
    logic [1:0] exp_lvl = 2'b00;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int ch = 0; ch < 2; ch++) begin
                xh[ch][k]     = 1'b0;
                xh[ch][k-1]   = 1'b0;
                m_lvl[ch]     = 1'b0;
                last_tog[ch]  = k;
                rise_at[ch]   = -1;
            end
            exp_z   = 2'b00;
            exp_lvl = 2'b00;
        end else begin
            if (k >= MAXC - 2) begin
                $display("FAIL model_capacity: k=%0d, limit %0d", k, MAXC - 2);
                $fatal(1);
            end
            k = k + 1;
            for (int ch = 0; ch < 2; ch++) begin
                bit tog, rise, fall, fire;
                int age;
                xh[ch][k] = x[ch];
                // Level flips once the synchronised input (x two edges back)
                // has disagreed on each of the last D edges since the last flip.
                tog = ((k - last_tog[ch]) >= D);
                if (tog) begin
                    for (int j = k - D + 1; j <= k; j++) begin
                        if (xh[ch][j-2] == m_lvl[ch]) tog = 1'b0;
                    end
                end
                rise = tog && !m_lvl[ch];
                fall = tog && m_lvl[ch];
                if (rise && rep_en[ch] && mode[0]) begin
                    rise_at[ch] = k;
                end else if (fall || !rep_en[ch] || !mode[0]) begin
                    rise_at[ch] = -1;
                end
                age  = k - rise_at[ch];
                fire = (rise_at[ch] >= 0) && ((age == H) || ((age > H) && (((age - H) % R) == 0)));
                if (tog) begin
                    m_lvl[ch]    = !m_lvl[ch];
                    last_tog[ch] = k;
                end
                exp_z[ch]   = (rise && mode[0]) || (fall && mode[1]) || fire;
                exp_lvl[ch] = m_lvl[ch];
            end
        end
    end

    task automatic chk(input string name, input int act, input int want);
        n_chk = n_chk + 1;
        if (act != want) begin
            n_fail = n_fail + 1;
            $display("FAIL %s @edge %0d: got %0d, expected %0d", name, k, act, want);
        end
    endtask

    // One clock cycle: compare against the model on the falling edge, log pulses.
    task automatic tick();
        @(negedge clk);
        chk("z_vs_model", int'(z), int'(exp_z));
        chk("level_vs_model", int'(level), int'(exp_lvl));
        if (z[0]) pz0.push_back(k);
        if (z[1]) pz1.push_back(k);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic clear_logs();
        pz0.delete();
        pz1.delete();
    endtask

    initial begin
        int e0, r0, p;
        int offs[5];
        rst_n  = 1'b0;
        x      = 2'b00;
        mode   = MODE_OFF;
        rep_en = 2'b00;
        ticks(3);
        chk("reset_level", int'(level), 0);
        chk("reset_z", int'(z), 0);
        rst_n = 1'b1;
        ticks(4);

        // Rise-only press on channel 0: level and single pulse at e0+5.
        mode = MODE_RISE;
        clear_logs();
        e0 = k + 1;
        x  = 2'b01;
        ticks(12);
        chk("t1_level", int'(level), 1);
        chk("t1_npulse0", pz0.size(), 1);
        if (pz0.size() >= 1) chk("t1_pulse_time", pz0[0] - e0, 5);
        chk("t1_npulse1", pz1.size(), 0);
        x = 2'b00;
        ticks(12);
        chk("t1_no_fall_pulse", pz0.size(), 1);

        // Short glitch, both edges selected: nothing happens.
        mode = MODE_BOTH;
        clear_logs();
        x = 2'b01;
        ticks(3);
        x = 2'b00;
        ticks(10);
        chk("t2_npulse", pz0.size(), 0);
        chk("t2_level", int'(level), 0);

        // Both edges, no repeat: rise and fall pulses only.
        clear_logs();
        e0 = k + 1;
        x  = 2'b01;
        ticks(20);
        r0 = k + 1;
        x  = 2'b00;
        ticks(12);
        chk("t3_npulse", pz0.size(), 2);
        if (pz0.size() == 2) begin
            chk("t3_rise_time", pz0[0] - e0, 5);
            chk("t3_fall_time", pz0[1] - r0, 5);
        end

        // Auto-repeat on channel 0.
        mode   = MODE_RISE;
        rep_en = 2'b01;
        clear_logs();
        e0 = k + 1;
        x  = 2'b01;
        ticks(20);
        x = 2'b00;
        ticks(20);
        offs = '{0, 8, 11, 14, 17};
        chk("t4_npulse", pz0.size(), 5);
        if (pz0.size() == 5) begin
            for (int i = 0; i < 5; i++) chk("t4_pulse_offset", pz0[i] - (e0 + 5), offs[i]);
        end

        // Reset mid-hold restarts as a fresh press.
        clear_logs();
        e0 = k + 1;
        p  = e0 + 5;
        x  = 2'b01;
        ticks(11);
        rst_n = 1'b0;
        tick();
        chk("t5_rst_level_a", int'(level), 0);
        chk("t5_rst_z_a", int'(z), 0);
        tick();
        chk("t5_rst_level_b", int'(level), 0);
        chk("t5_rst_z_b", int'(z), 0);
        rst_n = 1'b1;
        r0 = k + 1;
        ticks(30);
        x = 2'b00;
        ticks(15);
        chk("t5_enough_pulses", int'(pz0.size() >= 4), 1);
        if (pz0.size() >= 4) begin
            chk("t5_first", pz0[0], p);
            chk("t5_rise_after_rst", pz0[1] - r0, 5);
            chk("t5_rep1", pz0[2] - r0, 13);
            chk("t5_rep2", pz0[3] - r0, 16);
        end

        // Mode switched while held: no pulse at the switch, one on release.
        rep_en = 2'b00;
        mode   = MODE_RISE;
        clear_logs();
        x = 2'b01;
        ticks(10);
        mode = MODE_FALL;
        ticks(5);
        chk("t6_no_switch_pulse", pz0.size(), 1);
        r0 = k + 1;
        x  = 2'b00;
        ticks(10);
        chk("t6_npulse", pz0.size(), 2);
        if (pz0.size() == 2) chk("t6_fall_time", pz0[1] - r0, 5);

        // Simultaneous press on both channels pulses both in the same cycle.
        mode = MODE_BOTH;
        clear_logs();
        e0 = k + 1;
        x  = 2'b11;
        ticks(10);
        chk("t7_np0", pz0.size(), 1);
        chk("t7_np1", pz1.size(), 1);
        if (pz0.size() == 1 && pz1.size() == 1) begin
            chk("t7_time0", pz0[0] - e0, 5);
            chk("t7_time1", pz1[0] - e0, 5);
        end
        x = 2'b00;
        ticks(10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
